madgwick_wb_unit: RTL and testbench
===================================

Name: madgwick_wb_unit

Overview:
- Wishbone-classic slave wrapping one fixed-point quaternion attitude-update step (gyro-integration part of the Madgwick filter).
- Host writes accel/gyro samples, sets start, polls done (or takes inta_o), then reads the updated quaternion.
- Sits on the SoC peripheral bus.
- The quaternion state is retained between updates, so repeated starts integrate successive samples.

Parameters:
- ACC_WIDTH, 16, signed accelerometer sample width.
- GYRO_WIDTH, 16, signed gyro sample width, format Q4.12 rad/s.
- Q_WIDTH, 32, signed quaternion component width, format Q2.30.
- DT_SHIFT, 8, integration step dt = 2^-DT_SHIFT s.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- adr_i  in  6  byte address, word aligned.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- we_i  in  1  write enable.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle valid.
- ack_o  out  1  transfer acknowledge.
- inta_o  out  1  interrupt, active-high level.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 enable, bit1 start, bit2 done (read-only), bit3 int_en; other bits read 0.
  - 0x04/0x08/0x0C: a_x/a_y/a_z, stored in low ACC_WIDTH bits, sign-extended on read.
  - 0x10/0x14/0x18: w_x/w_y/w_z, low GYRO_WIDTH bits, sign-extended on read.
  - 0x1C/0x20/0x24/0x28: q_w/q_x/q_y/q_z.
  - Unmapped addresses: writes ignored, read 0, still acked.
- Bus timing:
  - ack_o is registered. It asserts the cycle after stb_i&cyc_i is sampled with ack_o=0, and lasts exactly one cycle; strobe held after ack gets a new ack two cycles later.
  - Write takes effect on the ack cycle.
  - dat_o is registered with ack_o and holds its value until the next read ack.
- Reset values:
  - ack_o=0, dat_o=0, inta_o=0, all CTRL bits 0.
  - Accel and gyro registers 0.
  - q_w=0x40000000 (1.0), q_x=q_y=q_z=0.
- FSM states: IDLE, MAC, UPDATE, DONE.
  - IDLE->MAC when a CTRL write sets start 0->1 while the written enable=1. Gyro and q values are snapshotted at that point.
  - MAC lasts 12 cycles: one signed multiply q_i*w_j per cycle, accumulated into four 50-bit accumulators:
    - acc_w = -x*gx - y*gy - z*gz
    - acc_x = w*gx + y*gz - z*gy
    - acc_y = w*gy - x*gz + z*gx
    - acc_z = w*gz + x*gy - y*gx
  - UPDATE (1 cycle): q_i += acc_i >>> (12+1+DT_SHIFT), arithmetic shift; the sum saturates to signed Q_WIDTH. Then done<=1 and state goes to DONE.
  - done is visible on a CTRL read issued 14+ cycles after the start-write ack.
  - DONE->IDLE when a CTRL write clears start; done clears on that same write.
- Writes to q or gyro registers while in MAC/UPDATE are ignored, and so is start re-assertion.
- Clearing enable mid-operation aborts to IDLE, leaves q unchanged and done=0.
- inta_o = done & int_en, registered.
- rst at any time returns all state to reset values, including mid-computation.
- Accelerometer registers are storage only in this revision and do not affect q.

Optional Feature:
- Macro MADGWICK_DEBUG_PORTS_EN.
- Defined: extra outputs are added:
  - a_x/y/z_debug (ACC_WIDTH), w_x/y/z_debug (GYRO_WIDTH), q_w/x/y/z_debug (Q_WIDTH), driven directly from the registers.
  - enable_debug, start_debug, done_debug, int_enable_debug.
  - busy_debug, high in MAC/UPDATE.
- Undefined: these ports do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header madgwick_defines: ACC_WIDTH, GYRO_WIDTH, Q_WIDTH defaults, register offsets, CTRL bit indices, FSM state encodings, Q_ONE=0x40000000.
- One natural sub-module, madgwick_quat_step, holding the FSM, MAC and saturating update. The top keeps the Wishbone register file.

Test Plan:
- Reset then read CTRL -> dat_o=0x00; read q_w -> 0x40000000; ack_o is a single-cycle pulse one cycle after strobe.
- Write CTRL=0x09, read back -> 0x09. Write a_x=0x1838, w_x=0x3F1F, then read each -> 0x00001838 and 0x00003F1F.
- Identity q, gyro all 0, write CTRL=0x0B, poll -> CTRL reads 0x0F. q unchanged (0x40000000,0,0,0). inta_o=1.
- Identity q, w_x=0x1000 (1.0 rad/s), DT_SHIFT=8, start -> q_x=0x00200000, q_w=0x40000000, q_y=q_z=0. Write CTRL=0x09 -> done=0, inta_o=0.
- Start with enable=0 (CTRL=0x02) -> done never sets, q unchanged. Mid-MAC write CTRL=0x00 -> abort, q unchanged.
- Assert rst 5 cycles into MAC -> all registers at reset values, ack_o=0, inta_o=0.

Source files
------------

// File: rtl/madgwick_wb_unit_pkg.sv
// Shared constants for the Madgwick quaternion unit: default widths, register
// map, CTRL bit positions, FSM encoding and the MAC term schedule.
package madgwick_defines;

  localparam int ACC_WIDTH_DEF  = 16;
  localparam int GYRO_WIDTH_DEF = 16;
  localparam int Q_WIDTH_DEF    = 32;
  localparam int DT_SHIFT_DEF   = 8;
  localparam int GYRO_FRAC      = 12;

  localparam logic [31:0] Q_ONE = 32'h4000_0000;

  // Word index = adr[5:2]
  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_AX   = 4'd1;
  localparam logic [3:0] REG_AY   = 4'd2;
  localparam logic [3:0] REG_AZ   = 4'd3;
  localparam logic [3:0] REG_WX   = 4'd4;
  localparam logic [3:0] REG_WY   = 4'd5;
  localparam logic [3:0] REG_WZ   = 4'd6;
  localparam logic [3:0] REG_QW   = 4'd7;
  localparam logic [3:0] REG_QX   = 4'd8;
  localparam logic [3:0] REG_QY   = 4'd9;
  localparam logic [3:0] REG_QZ   = 4'd10;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_INT_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } step_state_e;

  // One product q[q_sel]*w[w_sel], added to or subtracted from acc[acc_sel].
  typedef struct packed {
    logic [1:0] q_sel;   // 0=w 1=x 2=y 3=z
    logic [1:0] w_sel;   // 0=gx 1=gy 2=gz
    logic [1:0] acc_sel; // 0=w 1=x 2=y 3=z
    logic       neg;
  } mac_term_t;

  localparam int MAC_TERMS = 12;

  function automatic mac_term_t mac_term(input logic [3:0] idx);
    case (idx)
      4'd0:    return {2'd1, 2'd0, 2'd0, 1'b1};
      4'd1:    return {2'd2, 2'd1, 2'd0, 1'b1};
      4'd2:    return {2'd3, 2'd2, 2'd0, 1'b1};
      4'd3:    return {2'd0, 2'd0, 2'd1, 1'b0};
      4'd4:    return {2'd2, 2'd2, 2'd1, 1'b0};
      4'd5:    return {2'd3, 2'd1, 2'd1, 1'b1};
      4'd6:    return {2'd0, 2'd1, 2'd2, 1'b0};
      4'd7:    return {2'd1, 2'd2, 2'd2, 1'b1};
      4'd8:    return {2'd3, 2'd0, 2'd2, 1'b0};
      4'd9:    return {2'd0, 2'd2, 2'd3, 1'b0};
      4'd10:   return {2'd1, 2'd1, 2'd3, 1'b0};
      4'd11:   return {2'd2, 2'd0, 2'd3, 1'b1};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/madgwick_wb_unit_if.sv
// Wishbone-classic slave bus bundle for the Madgwick unit, including its
// interrupt line.
interface madgwick_wb_unit_if;
  logic [5:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic        inta_o;

  modport slave  (input  adr_i, dat_i, we_i, stb_i, cyc_i, output dat_o, ack_o, inta_o);
  modport master (output adr_i, dat_i, we_i, stb_i, cyc_i, input  dat_o, ack_o, inta_o);
endinterface

// File: rtl/madgwick_quat_step.sv
// One gyro-integration step: snapshot q and w, run a 12-cycle serial MAC of
// the quaternion product, then add the scaled result to q with saturation.
module madgwick_quat_step
  import madgwick_defines::*;
#(
  parameter int GYRO_WIDTH = GYRO_WIDTH_DEF,
  parameter int Q_WIDTH    = Q_WIDTH_DEF,
  parameter int DT_SHIFT   = DT_SHIFT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          release_i,
  input  logic [3:0][Q_WIDTH-1:0]       q_i,
  input  logic [2:0][GYRO_WIDTH-1:0]    w_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          upd_valid_o,
  output logic [3:0][Q_WIDTH-1:0]       q_new_o
);

  localparam int PROD_W = Q_WIDTH + GYRO_WIDTH;
  localparam int ACC_W  = PROD_W + 2;
  localparam int SUM_W  = ACC_W + 1;
  localparam int SHIFT  = GYRO_FRAC + 1 + DT_SHIFT;
  localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << (Q_WIDTH - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  step_state_e                state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic [3:0][ACC_W-1:0]      acc_q, acc_d;
  logic [3:0][Q_WIDTH-1:0]    q_snap_q;
  logic [2:0][GYRO_WIDTH-1:0] w_snap_q;
  logic                       snap_en;

  mac_term_t                  term;
  logic signed [PROD_W-1:0]   q_op, w_op, prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [SUM_W-1:0]    sum;

  always_comb begin
    term     = mac_term(cnt_q);
    q_op     = PROD_W'($signed(q_snap_q[term.q_sel]));
    w_op     = PROD_W'($signed(w_snap_q[term.w_sel]));
    prod     = q_op * w_op;
    prod_ext = ACC_W'(prod);
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    acc_d       = acc_q;
    snap_en     = 1'b0;
    upd_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_MAC;
          cnt_d   = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          snap_en = 1'b1;
        end
      end
      ST_MAC: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          acc_d[term.acc_sel] = term.neg ? acc_q[term.acc_sel] - prod_ext
                                         : acc_q[term.acc_sel] + prod_ext;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(MAC_TERMS - 1)) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          upd_valid_o = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort_i || release_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // dt and the 1/2 of the quaternion derivative fold into one arithmetic shift.
  always_comb begin
    sum     = '0;
    q_new_o = '0;
    for (int i = 0; i < 4; i++) begin
      sum = SUM_W'($signed(q_snap_q[i])) + SUM_W'($signed(acc_q[i]) >>> SHIFT);
      if (sum > SAT_MAX)      q_new_o[i] = SAT_MAX[Q_WIDTH-1:0];
      else if (sum < SAT_MIN) q_new_o[i] = SAT_MIN[Q_WIDTH-1:0];
      else                    q_new_o[i] = sum[Q_WIDTH-1:0];
    end
  end

  // NOTE: datapath registers are reset as well, so a mid-step rst leaves no stale operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      q_snap_q <= '0;
      w_snap_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      if (snap_en) begin
        q_snap_q <= q_i;
        w_snap_q <= w_i;
      end
    end
  end

  assign busy_o = (state_q == ST_MAC) || (state_q == ST_UPDATE);
  assign done_o = done_q;

endmodule

// File: rtl/madgwick_wb_unit.sv
// Wishbone register file around madgwick_quat_step. Defining
// MADGWICK_DEBUG_PORTS_EN adds direct observation ports for all registers.
module madgwick_wb_unit
  import madgwick_defines::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int GYRO_WIDTH = GYRO_WIDTH_DEF,
  parameter int Q_WIDTH    = Q_WIDTH_DEF,
  parameter int DT_SHIFT   = DT_SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  madgwick_wb_unit_if.slave    bus
`ifdef MADGWICK_DEBUG_PORTS_EN
  ,
  output logic [ACC_WIDTH-1:0]  a_x_debug,
  output logic [ACC_WIDTH-1:0]  a_y_debug,
  output logic [ACC_WIDTH-1:0]  a_z_debug,
  output logic [GYRO_WIDTH-1:0] w_x_debug,
  output logic [GYRO_WIDTH-1:0] w_y_debug,
  output logic [GYRO_WIDTH-1:0] w_z_debug,
  output logic [Q_WIDTH-1:0]    q_w_debug,
  output logic [Q_WIDTH-1:0]    q_x_debug,
  output logic [Q_WIDTH-1:0]    q_y_debug,
  output logic [Q_WIDTH-1:0]    q_z_debug,
  output logic                  enable_debug,
  output logic                  start_debug,
  output logic                  done_debug,
  output logic                  int_enable_debug,
  output logic                  busy_debug
`endif
);

  localparam logic [Q_WIDTH-1:0] Q_INIT = Q_WIDTH'(1) << (Q_WIDTH - 2);

  logic                       ack_q, inta_q;
  logic [31:0]                dat_q, rd_data;
  logic                       enable_q, start_q, int_en_q;
  logic [2:0][ACC_WIDTH-1:0]  a_q;
  logic [2:0][GYRO_WIDTH-1:0] w_q;
  logic [3:0][Q_WIDTH-1:0]    q_q, q_new;

  logic       req, wr, rd, ctrl_wr;
  logic       start_pulse, abort, release_start;
  logic       busy, done, upd_valid;
  logic [3:0] idx;
  logic       unused_adr_bits;

  assign idx             = bus.adr_i[5:2];
  assign unused_adr_bits = ^bus.adr_i[1:0];
  assign req             = bus.stb_i & bus.cyc_i & ~ack_q;
  assign wr              = req & bus.we_i;
  assign rd              = req & ~bus.we_i;
  assign ctrl_wr         = wr && (idx == REG_CTRL);

  // Only a 0->1 start edge with enable set launches a step.
  assign start_pulse   = ctrl_wr & bus.dat_i[CTRL_START] & ~start_q & bus.dat_i[CTRL_ENABLE];
  assign abort         = ctrl_wr & ~bus.dat_i[CTRL_ENABLE];
  assign release_start = ctrl_wr & ~bus.dat_i[CTRL_START];

  madgwick_quat_step #(
    .GYRO_WIDTH (GYRO_WIDTH),
    .Q_WIDTH    (Q_WIDTH),
    .DT_SHIFT   (DT_SHIFT)
  ) u_step (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_pulse),
    .abort_i     (abort),
    .release_i   (release_start),
    .q_i         (q_q),
    .w_i         (w_q),
    .busy_o      (busy),
    .done_o      (done),
    .upd_valid_o (upd_valid),
    .q_new_o     (q_new)
  );

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_CTRL:               rd_data = 32'({int_en_q, done, start_q, enable_q});
      REG_AX, REG_AY, REG_AZ: rd_data = 32'($signed(a_q[2'(idx - REG_AX)]));
      REG_WX, REG_WY, REG_WZ: rd_data = 32'($signed(w_q[2'(idx - REG_WX)]));
      REG_QW, REG_QX, REG_QY, REG_QZ: rd_data = 32'($signed(q_q[2'(idx - REG_QW)]));
      default:                rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      inta_q   <= 1'b0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      int_en_q <= 1'b0;
      a_q      <= '0;
      w_q      <= '0;
      q_q      <= '0;
      q_q[0]   <= Q_INIT;
    end else begin
      ack_q  <= req;
      inta_q <= done & int_en_q;
      if (rd) dat_q <= rd_data;
      if (upd_valid) q_q <= q_new;
      if (wr) begin
        case (idx)
          REG_CTRL: begin
            enable_q <= bus.dat_i[CTRL_ENABLE];
            start_q  <= bus.dat_i[CTRL_START];
            int_en_q <= bus.dat_i[CTRL_INT_EN];
          end
          REG_AX, REG_AY, REG_AZ: a_q[2'(idx - REG_AX)] <= bus.dat_i[ACC_WIDTH-1:0];
          REG_WX, REG_WY, REG_WZ: if (!busy) w_q[2'(idx - REG_WX)] <= bus.dat_i[GYRO_WIDTH-1:0];
          REG_QW, REG_QX, REG_QY, REG_QZ: if (!busy) q_q[2'(idx - REG_QW)] <= bus.dat_i[Q_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.dat_o  = dat_q;
  assign bus.inta_o = inta_q;

`ifdef MADGWICK_DEBUG_PORTS_EN
  assign a_x_debug        = a_q[0];
  assign a_y_debug        = a_q[1];
  assign a_z_debug        = a_q[2];
  assign w_x_debug        = w_q[0];
  assign w_y_debug        = w_q[1];
  assign w_z_debug        = w_q[2];
  assign q_w_debug        = q_q[0];
  assign q_x_debug        = q_q[1];
  assign q_y_debug        = q_q[2];
  assign q_z_debug        = q_q[3];
  assign enable_debug     = enable_q;
  assign start_debug      = start_q;
  assign done_debug       = done;
  assign int_enable_debug = int_en_q;
  assign busy_debug       = busy;
`endif

endmodule

// File: tb/tb_madgwick_wb_unit.sv
// Directed bench for madgwick_wb_unit: bus timing, register map, integration
// results with hand-computed quaternions, abort and reset behaviour.
module tb_madgwick_wb_unit;
  import madgwick_defines::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  madgwick_wb_unit_if bus_if();

  madgwick_wb_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [5:0] adr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    logic ok;
    ok = 1'b0;
    bus_if.adr_i = adr;
    bus_if.dat_i = wdata;
    bus_if.we_i  = we;
    bus_if.stb_i = 1'b1;
    bus_if.cyc_i = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.ack_o) ok = 1'b1;
    end
    rdata = bus_if.dat_o;
    bus_if.stb_i = 1'b0;
    bus_if.cyc_i = 1'b0;
    bus_if.we_i  = 1'b0;
    if (!ok) check("ack_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wb_write(input logic [5:0] adr, input logic [31:0] data);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, adr, data, unused_rd);
  endtask

  task automatic wb_read_check(input string tag, input logic [5:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 32'h0, r);
    check(tag, r, exp);
  endtask

  // Poll CTRL until done shows, bounded; a started step with int_en must read 0x0F.
  task automatic wait_done(input string tag);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 40 && !r[CTRL_DONE]; n++) wb_xfer(1'b0, 6'h00, 32'h0, r);
    check(tag, r, 32'h0000_000F);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.adr_i = '0;
    bus_if.dat_i = '0;
    bus_if.we_i  = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.cyc_i = 1'b0;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;

    // Reset state and ack pulse shape with strobe held.
    check("rst_ack", 32'(bus_if.ack_o), 32'd0);
    check("rst_inta", 32'(bus_if.inta_o), 32'd0);
    check("rst_dat", bus_if.dat_o, 32'h0);
    bus_if.adr_i = 6'h00;
    bus_if.we_i  = 1'b0;
    bus_if.stb_i = 1'b1;
    bus_if.cyc_i = 1'b1;
    idle_cycles(1);
    check("ack_first", 32'(bus_if.ack_o), 32'd1);
    check("rd_ctrl_rst", bus_if.dat_o, 32'h0);
    idle_cycles(1);
    check("ack_single", 32'(bus_if.ack_o), 32'd0);
    idle_cycles(1);
    check("ack_again", 32'(bus_if.ack_o), 32'd1);
    bus_if.stb_i = 1'b0;
    bus_if.cyc_i = 1'b0;
    wb_read_check("rst_qw", 6'h1C, 32'h4000_0000);
    wb_read_check("rst_qx", 6'h20, 32'h0);

    // Register map, sign extension, unmapped space.
    wb_write(6'h00, 32'h09);
    wb_read_check("ctrl_rw", 6'h00, 32'h09);
    wb_write(6'h04, 32'h1838);
    wb_write(6'h10, 32'h3F1F);
    wb_read_check("ax_rw", 6'h04, 32'h0000_1838);
    wb_read_check("wx_rw", 6'h10, 32'h0000_3F1F);
    wb_write(6'h08, 32'h1234_8001);
    wb_read_check("ay_sext", 6'h08, 32'hFFFF_8001);
    wb_write(6'h18, 32'h0000_F000);
    wb_read_check("wz_sext", 6'h18, 32'hFFFF_F000);
    wb_write(6'h18, 32'h0);
    wb_write(6'h30, 32'hDEAD_BEEF);
    wb_read_check("unmapped", 6'h30, 32'h0);
    wb_write(6'h10, 32'h0);

    // Zero gyro: done and interrupt, q untouched.
    wb_write(6'h00, 32'h0B);
    wb_read_check("ctrl_busy", 6'h00, 32'h0B);
    wait_done("done_zero");
    wb_read_check("zero_qw", 6'h1C, 32'h4000_0000);
    wb_read_check("zero_qx", 6'h20, 32'h0);
    wb_read_check("zero_qy", 6'h24, 32'h0);
    wb_read_check("zero_qz", 6'h28, 32'h0);
    idle_cycles(2);
    check("inta_set", 32'(bus_if.inta_o), 32'd1);
    wb_write(6'h00, 32'h09);
    idle_cycles(2);
    check("inta_clr", 32'(bus_if.inta_o), 32'd0);
    wb_read_check("ctrl_clr", 6'h00, 32'h09);

    // w_x = 1.0 rad/s from identity: q_x gains 2^30 * 2^-9.
    wb_write(6'h10, 32'h1000);
    wb_write(6'h00, 32'h0B);
    wait_done("done_wx1");
    wb_read_check("wx1_qw", 6'h1C, 32'h4000_0000);
    wb_read_check("wx1_qx", 6'h20, 32'h0020_0000);
    wb_read_check("wx1_qy", 6'h24, 32'h0);
    wb_read_check("wx1_qz", 6'h28, 32'h0);
    wb_write(6'h00, 32'h09);
    wb_read_check("ctrl_rel", 6'h00, 32'h09);

    // Second step integrates on top; q write during MAC is dropped.
    wb_write(6'h00, 32'h0B);
    wb_write(6'h24, 32'h1111_1111);
    wait_done("done_wx2");
    wb_read_check("wx2_qw", 6'h1C, 32'h3FFF_F000);
    wb_read_check("wx2_qx", 6'h20, 32'h0040_0000);
    wb_read_check("wx2_qy_locked", 6'h24, 32'h0);
    wb_write(6'h00, 32'h09);

    // Positive saturation of q_x, non-saturating negative update of q_w.
    wb_write(6'h1C, 32'h7FFF_FFFF);
    wb_write(6'h20, 32'h7FF0_0000);
    wb_write(6'h10, 32'h7FFF);
    wb_write(6'h00, 32'h0B);
    wait_done("done_sat");
    wb_read_check("sat_qw", 6'h1C, 32'h7E00_43FE);
    wb_read_check("sat_qx", 6'h20, 32'h7FFF_FFFF);
    wb_read_check("sat_qy", 6'h24, 32'h0);
    wb_read_check("sat_qz", 6'h28, 32'h0);
    wb_write(6'h00, 32'h09);

    // Start without enable does nothing; clearing enable mid-MAC aborts.
    wb_write(6'h00, 32'h02);
    idle_cycles(30);
    wb_read_check("noen_ctrl", 6'h00, 32'h02);
    wb_read_check("noen_qx", 6'h20, 32'h7FFF_FFFF);
    wb_write(6'h00, 32'h00);
    wb_write(6'h00, 32'h03);
    idle_cycles(4);
    wb_write(6'h00, 32'h00);
    idle_cycles(30);
    wb_read_check("abort_ctrl", 6'h00, 32'h0);
    wb_read_check("abort_qw", 6'h1C, 32'h7E00_43FE);
    wb_read_check("abort_qx", 6'h20, 32'h7FFF_FFFF);

    // Reset in the middle of MAC.
    wb_write(6'h00, 32'h0B);
    idle_cycles(5);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    check("mrst_ack", 32'(bus_if.ack_o), 32'd0);
    check("mrst_inta", 32'(bus_if.inta_o), 32'd0);
    wb_read_check("mrst_ctrl", 6'h00, 32'h0);
    wb_read_check("mrst_ax", 6'h04, 32'h0);
    wb_read_check("mrst_ay", 6'h08, 32'h0);
    wb_read_check("mrst_wx", 6'h10, 32'h0);
    wb_read_check("mrst_qw", 6'h1C, Q_ONE);
    wb_read_check("mrst_qx", 6'h20, 32'h0);
    idle_cycles(20);
    wb_read_check("mrst_idle", 6'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
